// File: rtl/seq_logic_pkg.sv
// Shared encodings for the sequential bitwise logic unit: op codes, FSM states,
// and a helper that sizes the beat counter.
// Ports: none (package only).
package seq_logic_pkg;

   typedef enum logic [2:0] {
      OP_AND    = 3'd0,
      OP_OR     = 3'd1,
      OP_XOR    = 3'd2,
      OP_NAND   = 3'd3,
      OP_NOR    = 3'd4,
      OP_XNOR   = 3'd5,
      OP_PASS_A = 3'd6,
      OP_NOT_A  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // A single-beat configuration still needs a 1-bit counter to keep the
   // counter declaration legal.
   function automatic int beat_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_logic_unit_if.sv
// Handshake and data bundle for seq_logic_unit: operand/op input channel,
// result output channel, and accumulator controls/status.
// Ports: master = producer/consumer side, slave = the logic unit.
interface seq_logic_unit_if #(
   parameter int WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic             accum;
   logic             acc_clr;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             parity;
   logic [WIDTH-1:0] acc;

   modport master (
      output in_valid, op, accum, acc_clr, a, b, out_ready,
      input  in_ready, out_valid, result, parity, acc
   );

   modport slave (
      input  in_valid, op, accum, acc_clr, a, b, out_ready,
      output in_ready, out_valid, result, parity, acc
   );

endinterface

// File: rtl/logic_slice.sv
// One SLICE-wide bitwise operation, purely combinational, built from NAND gates.
// Latency: 0 cycles. Backpressure: none (no state, no handshake).
// Ports: op_i operation code, a_i/b_i operand slices, y_o result slice.
module logic_slice
   import seq_logic_pkg::*;
#(
   parameter int SLICE = 4
) (
   input  op_e              op_i,
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   output logic [SLICE-1:0] y_o
);

   logic [SLICE-1:0] n_ab;
   logic [SLICE-1:0] n_aa;
   logic [SLICE-1:0] n_bb;
   logic [SLICE-1:0] and_w;
   logic [SLICE-1:0] or_w;
   logic [SLICE-1:0] xor_w;

   // Every function reduces to NAND2: AND = NAND(n,n), OR = NAND(~a,~b),
   // XOR = classic four-NAND form; the inverting ops are just one more NAND.
   assign n_ab  = ~(a_i & b_i);
   assign n_aa  = ~(a_i & a_i);
   assign n_bb  = ~(b_i & b_i);
   assign and_w = ~(n_ab & n_ab);
   assign or_w  = ~(n_aa & n_bb);
   assign xor_w = ~(~(a_i & n_ab) & ~(b_i & n_ab));

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_AND:    y_o = and_w;
         OP_OR:     y_o = or_w;
         OP_XOR:    y_o = xor_w;
         OP_NAND:   y_o = n_ab;
         OP_NOR:    y_o = ~(or_w & or_w);
         OP_XNOR:   y_o = ~(xor_w & xor_w);
         OP_PASS_A: y_o = a_i;
         OP_NOT_A:  y_o = n_aa;
         default:   y_o = '0;
      endcase
   end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: SLICE bits per beat, optional XOR checksum.
// Latency: WIDTH/SLICE cycles from accept to out_valid; one op per N+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low), bus (slave modport of seq_logic_unit_if).
module seq_logic_unit
   import seq_logic_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic            clk,
   input logic            rst_n,
   seq_logic_unit_if.slave bus
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = beat_cnt_w(N);

   if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
      $error("seq_logic_unit: WIDTH must be a non-zero multiple of SLICE");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   op_e              op_q, op_d;
   logic             accum_q, accum_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_y;
   logic [WIDTH-1:0] work_nx;
   logic             last_beat;

   // Beat-indexed slice mux. Constant part-selects under a compare keep the
   // index widths exact for any WIDTH/SLICE pairing.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int k = 0; k < N; k++) begin
         if (cnt_q == CW'(k)) begin
            slice_a = a_q[k*SLICE +: SLICE];
            slice_b = b_q[k*SLICE +: SLICE];
         end
      end
   end

   logic_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .op_i (op_q),
      .a_i  (slice_a),
      .b_i  (slice_b),
      .y_o  (slice_y)
   );

   // Work word with the current beat merged in; on the last beat this is the
   // complete result, so result/acc take it directly instead of work_q.
   always_comb begin
      work_nx = work_q;
      for (int k = 0; k < N; k++) begin
         if (cnt_q == CW'(k)) begin
            work_nx[k*SLICE +: SLICE] = slice_y;
         end
      end
   end

   assign last_beat = (cnt_q == CW'(N - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      accum_d  = accum_q;
      work_d   = work_q;
      result_d = result_q;
      acc_d    = acc_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               op_d    = op_e'(bus.op);
               accum_d = bus.accum;
               cnt_d   = '0;
               work_d  = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            work_d = work_nx;
            if (last_beat) begin
               result_d = work_nx;
               cnt_d    = '0;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Clear first, then fold: a clear landing on the final beat of an
      // accumulating op leaves exactly that op's result in acc.
      if (bus.acc_clr) begin
         acc_d = '0;
      end
      if ((state_q == BUSY) && last_beat && accum_q) begin
         acc_d = acc_d ^ work_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_AND;
         accum_q  <= 1'b0;
         work_q   <= '0;
         result_q <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         accum_q  <= accum_d;
         work_q   <= work_d;
         result_q <= result_d;
         acc_q    <= acc_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.parity    = ^result_q;
   assign bus.acc       = acc_q;

endmodule
